ans_ht_ltf_seq_ctrl: RTL

Per-packet sequencer that sits directly upstream of the HT-LTF generator and drives its control inputs. For each packet it builds the 128-bit obfuscation coefficient word with an LFSR, pulses the generator's start, and waits for the generator to finish its IFFT. It then requests output once the TX datapath is ready, and forwards the generator's HT-LTF samples as a counted, framed stream. It also supervises the generator with a timeout and can reset it.

---
 rtl/ans_ht_ltf_pkg.sv | 40 ++++
 rtl/ans_ht_ltf_seq_ctrl_if.sv | 48 ++++
 rtl/ans_obf_lfsr.sv | 34 +++
 rtl/ans_ht_ltf_seq_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ans_ht_ltf_pkg.sv
// ans_ht_ltf_pkg
//   Types and constants shared by the HT-LTF sequencer, its LFSR and its bus
//   interface. It holds the sequencer state encoding, the 2-bit coefficient
//   codes consumed by the generator, the LFSR tap mask and the coefficient
//   word width. It also holds the LFSR next-state helper.
package ans_ht_ltf_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_COEFF   = 4'd1,
    ST_KICK    = 4'd2,
    ST_PREP    = 4'd3,
    ST_WAIT_TX = 4'd4,
    ST_REQ     = 4'd5,
    ST_STREAM  = 4'd6,
    ST_DONE    = 4'd7,
    ST_GEN_RST = 4'd8
  } seq_state_t;

  // Coefficient codes as decoded by the HT-LTF generator.
  localparam logic [1:0] COEF_X1   = 2'b00;
  localparam logic [1:0] COEF_DIV8 = 2'b01;
  localparam logic [1:0] COEF_DIV2 = 2'b10;
  localparam logic [1:0] COEF_DIV4 = 2'b11;

  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam int          OBF_COEFF_W = 128;
  localparam int          NUM_COEFFS  = OBF_COEFF_W / 2;

  // One shared counter serves coefficient index, prep delay, request
  // timeout and sample count; 16 bits covers every parameter range in use.
  localparam int CNT_W = 16;

  // Galois right-shift step: shift out bit 0 and fold the taps back in
  // whenever that bit was set.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/ans_ht_ltf_seq_ctrl_if.sv
// ans_ht_ltf_seq_ctrl_if
//   Bundles every non-clock/reset signal of the HT-LTF sequencer.
//   master : the sequencer side. It receives the TX FSM requests and the
//            generator status, and drives the generator controls and the
//            LTF stream.
//   slave  : the environment side (TX FSM, generator, stream consumer).
//   Signals:
//     start, seed_load, seed, obf_enable : requests from the TX FSM
//     tx_ready                           : downstream ready for the stream
//     gen_started, gen_sample            : generator status and data
//     gen_reset, letsgo, givemeoutput    : generator controls
//     obf_coeff                          : 64 x 2-bit coefficient word
//     ltf_tdata, ltf_tvalid, ltf_tlast   : framed sample stream (no backpressure)
//     busy, done, err_timeout            : status
interface ans_ht_ltf_seq_ctrl_if;
  import ans_ht_ltf_pkg::*;

  logic                   start;
  logic                   seed_load;
  logic [31:0]            seed;
  logic                   obf_enable;
  logic                   tx_ready;
  logic                   gen_started;
  logic [31:0]            gen_sample;
  logic                   gen_reset;
  logic                   letsgo;
  logic                   givemeoutput;
  logic [OBF_COEFF_W-1:0] obf_coeff;
  logic [31:0]            ltf_tdata;
  logic                   ltf_tvalid;
  logic                   ltf_tlast;
  logic                   busy;
  logic                   done;
  logic                   err_timeout;

  modport master (
    input  start, seed_load, seed, obf_enable, tx_ready, gen_started, gen_sample,
    output gen_reset, letsgo, givemeoutput, obf_coeff,
    output ltf_tdata, ltf_tvalid, ltf_tlast, busy, done, err_timeout
  );

  modport slave (
    output start, seed_load, seed, obf_enable, tx_ready, gen_started, gen_sample,
    input  gen_reset, letsgo, givemeoutput, obf_coeff,
    input  ltf_tdata, ltf_tvalid, ltf_tlast, busy, done, err_timeout
  );

endinterface

// File: rtl/ans_obf_lfsr.sv
// ans_obf_lfsr
//   32-bit Galois LFSR that supplies obfuscation coefficients.
//   Ports:
//     clk, rstn : clock, asynchronous active-low reset (state resets to 1)
//     load      : load seed (a zero seed is replaced by 1, which avoids lock-up)
//     seed      : seed value
//     step      : advance one step (load has priority)
//     coeff     : current state bits [1:0], the next coefficient to use
module ans_obf_lfsr
  import ans_ht_ltf_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [1:0]  coeff
);

  logic [31:0] lfsr_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_reg <= 32'd1;
    end else if (load) begin
      lfsr_reg <= (seed == 32'd0) ? 32'd1 : seed;
    end else if (step) begin
      lfsr_reg <= lfsr_next(lfsr_reg);
    end
  end

  assign coeff = lfsr_reg[1:0];

endmodule

// File: rtl/ans_ht_ltf_seq_ctrl.sv
// ans_ht_ltf_seq_ctrl
//   Per-packet sequencer in front of the HT-LTF generator. For each packet it
//   fills the 128-bit coefficient word from the LFSR, pulses letsgo, waits out
//   the generator's IFFT, requests output once TX is ready, and forwards
//   NUM_SAMPLES generator samples as a framed stream. A request that goes
//   unanswered for TIMEOUT cycles flags err_timeout and resets the generator.
//   Ports:
//     clk, rstn : clock, asynchronous active-low reset
//     bus       : ans_ht_ltf_seq_ctrl_if.master (all control, status, data)
module ans_ht_ltf_seq_ctrl
  import ans_ht_ltf_pkg::*;
#(
  parameter int NUM_SAMPLES = 80,
  parameter int PREP_CYCLES = 160,
  parameter int TIMEOUT     = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  ans_ht_ltf_seq_ctrl_if.master   bus
);

  seq_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;

  logic             lfsr_load;
  logic             lfsr_step;
  logic [1:0]       lfsr_coeff;
  logic [1:0]       coeff_in;
  wire  [OBF_COEFF_W-1:0] obf_coeff_word;

  // LFSR only advances when real coefficients are drawn, so a packet sent
  // with obfuscation disabled leaves the sequence untouched.
  assign lfsr_load = (state_reg == ST_IDLE) && bus.seed_load;
  assign lfsr_step = (state_reg == ST_COEFF) && bus.obf_enable;
  assign coeff_in  = bus.obf_enable ? lfsr_coeff : COEF_X1;

  ans_obf_lfsr u_lfsr (
    .clk   (clk),
    .rstn  (rstn),
    .load  (lfsr_load),
    .seed  (bus.seed),
    .step  (lfsr_step),
    .coeff (lfsr_coeff)
  );

  // One 2-bit register per coefficient slot; slot k is written on COEFF
  // cycle k and then holds until the next packet's COEFF phase.
  for (genvar gi = 0; gi < NUM_COEFFS; gi++) begin : g_coeff
    logic [1:0] slot_reg;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        slot_reg <= COEF_X1;
      end else if ((state_reg == ST_COEFF) && (cnt_reg == CNT_W'(gi))) begin
        slot_reg <= coeff_in;
      end
    end
    assign obf_coeff_word[2*gi +: 2] = slot_reg;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic. cnt_reg is reused per state: coefficient index,
  // prep delay, request wait, sample index, generator-reset length.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_COEFF;
          cnt_next   = '0;
          err_next   = 1'b0;
        end
      end
      ST_COEFF: begin
        if (cnt_reg == CNT_W'(NUM_COEFFS - 1)) begin
          state_next = ST_KICK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_KICK: begin
        state_next = ST_PREP;
        cnt_next   = '0;
      end
      ST_PREP: begin
        if (cnt_reg == CNT_W'(PREP_CYCLES - 1)) begin
          state_next = ST_WAIT_TX;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_WAIT_TX: begin
        if (bus.tx_ready) begin
          state_next = ST_REQ;
          cnt_next   = '0;
        end
      end
      ST_REQ: begin
        // The cycle gen_started is first seen already carries sample 0,
        // so the stream counter starts at 1.
        if (bus.gen_started) begin
          state_next = ST_STREAM;
          cnt_next   = CNT_W'(1);
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          state_next = ST_GEN_RST;
          cnt_next   = '0;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_STREAM: begin
        if (cnt_reg == CNT_W'(NUM_SAMPLES - 1)) begin
          state_next = ST_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      ST_GEN_RST: begin
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode. Sample forwarding is combinational so the first sample
  // is passed in the very cycle gen_started rises.
  always_comb begin
    bus.letsgo       = (state_reg == ST_KICK);
    bus.givemeoutput = (state_reg == ST_REQ);
    bus.ltf_tvalid   = (state_reg == ST_STREAM) ||
                       ((state_reg == ST_REQ) && bus.gen_started);
    bus.ltf_tdata    = bus.ltf_tvalid ? bus.gen_sample : 32'h0;
    bus.ltf_tlast    = (state_reg == ST_STREAM) && (cnt_reg == CNT_W'(NUM_SAMPLES - 1));
    bus.busy         = (state_reg != ST_IDLE);
    bus.done         = (state_reg == ST_DONE);
    bus.err_timeout  = err_reg;
    bus.obf_coeff    = obf_coeff_word;
    // Generator is held in reset whenever this block is.
    bus.gen_reset    = !rstn || (state_reg == ST_GEN_RST);
  end

endmodule
